// File: rtl/icache_direct_if.sv
// icache_direct_if: fetch port plus refill port of the direct-mapped I-cache.
//   pc/inst_ce/flush  -> cache    instr/cache_hit <- cache
//   mem_req/mem_addr  <- cache    mem_rdata/mem_ack -> cache
// slave = cache side, master = core + backing memory side.
interface icache_direct_if;
  logic [31:0] pc;
  logic        inst_ce;
  logic        flush;
  logic [31:0] instr;
  logic        cache_hit;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (output pc, inst_ce, flush, mem_rdata, mem_ack,
                  input  instr, cache_hit, mem_req, mem_addr);
  modport slave  (input  pc, inst_ce, flush, mem_rdata, mem_ack,
                  output instr, cache_hit, mem_req, mem_addr);
endinterface

// File: rtl/icache_direct.sv
// icache_direct: direct-mapped read-only instruction cache.
// Combinational hit path (zero latency); on a miss one whole line is refilled
// word by word with a req/ack handshake, addresses latched at the miss.
// Ports: clk, rst (async, active low), bus (icache_direct_if.slave).
// Optional: ICACHE_STATS_EN adds hit_cnt / miss_cnt outputs.
module icache_direct #(
  parameter int LINES      = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic clk,
  input  logic rst,
  icache_direct_if.slave bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);
  localparam int OFF   = $clog2(LINE_WORDS);
  localparam int IDX   = $clog2(LINES);
  localparam int TAG_W = 32 - IDX - OFF - 2;
  localparam int LA_W  = TAG_W + IDX;   // line address width

  typedef enum logic {IDLE, REFILL} state_t;

  state_t            state, state_nxt;
  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [31:0]       data_mem [LINES][LINE_WORDS];
  logic [LA_W-1:0]   rbase;
  logic [OFF-1:0]    cnt;
  logic              flush_pend;

  logic [OFF-1:0]    pc_off;
  logic [IDX-1:0]    pc_idx;
  logic [TAG_W-1:0]  pc_tag;
  logic [IDX-1:0]    rindex;
  logic [TAG_W-1:0]  rtag;
  logic              hit, start, wr, last;
  logic              pc_unused;

  assign pc_off    = bus.pc[OFF+1:2];
  assign pc_idx    = bus.pc[IDX+OFF+1:OFF+2];
  assign pc_tag    = bus.pc[31:IDX+OFF+2];
  assign pc_unused = ^bus.pc[1:0];
  assign rindex    = rbase[IDX-1:0];
  assign rtag      = rbase[LA_W-1:IDX];

  assign hit   = bus.inst_ce && (state == IDLE) && valid[pc_idx] && (tag_mem[pc_idx] == pc_tag);
  // flush in the same cycle suppresses the miss; it is re-evaluated next cycle
  assign start = (state == IDLE) && bus.inst_ce && !hit && !bus.flush;
  assign wr    = (state == REFILL) && bus.mem_ack;
  assign last  = wr && (&cnt);

  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else      state <= state_nxt;

  // next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = REFILL;
      REFILL:  if (last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // outputs; mem_req/mem_addr come straight from registers, so reset drops
  // the request asynchronously
  always_comb begin
    bus.cache_hit = hit;
    bus.instr     = hit ? data_mem[pc_idx][pc_off] : '0;
    bus.mem_req   = (state == REFILL);
    bus.mem_addr  = (state == REFILL) ? {rbase, cnt, 2'b00} : '0;
  end

  // control / valid bits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid      <= '0;
      rbase      <= '0;
      cnt        <= '0;
      flush_pend <= 1'b0;
    end else begin
      if (start) begin
        rbase          <= bus.pc[31:OFF+2];
        cnt            <= '0;
        valid[pc_idx]  <= 1'b0;   // partially written line must never hit
      end
      if ((state == IDLE) && bus.flush) valid <= '0;
      if (state == REFILL) begin
        if (bus.flush) flush_pend <= 1'b1;
        if (wr) cnt <= cnt + OFF'(1);
        if (last) begin
          // a flush seen anywhere during the refill also kills the new line
          if (flush_pend || bus.flush) valid <= '0;
          else                         valid[rindex] <= 1'b1;
          flush_pend <= 1'b0;
        end
      end
    end
  end

  // tag/data arrays, not reset
  always_ff @(posedge clk) begin
    if (wr)   data_mem[rindex][cnt] <= bus.mem_rdata;
    if (last) tag_mem[rindex]       <= rtag;
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (hit)   hit_cnt  <= hit_cnt + 32'd1;
      if (start) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif
endmodule
